// File: rtl/readback_pkg.sv
// Shared types and helpers for the register readback path.
// Holds the FSM encoding, frame length and parity helper.
package readback_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned DEF_N     = 8;
    localparam int unsigned FRAME_LEN = DEF_N + 1;

    function automatic int unsigned frame_len(input int unsigned n);
        return n + 1;
    endfunction

    // Even parity: the extra bit makes the total count of ones even.
    // Words narrower than 64 bits are zero-extended by the caller.
    function automatic logic even_parity(input logic [63:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/reg_readback_tx_if.sv
// Request/readback bundle between the register bank and the
// serial readback transmitter.
interface reg_readback_tx_if #(
    parameter int N = 8,
    parameter int M = 4,
    parameter int A = 2
);
    logic           rd_req;
    logic [A-1:0]   rd_addr;
    logic [M*N-1:0] regs_flat;
    logic           busy;
    logic           sdo;
    logic           sframe;
    logic           done;
    logic           err;

    modport master (
        output rd_req, rd_addr, regs_flat,
        input  busy, sdo, sframe, done, err
    );

    modport slave (
        input  rd_req, rd_addr, regs_flat,
        output busy, sdo, sframe, done, err
    );
endinterface

// File: rtl/reg_readback_tx_piso.sv
// Parallel-in serial-out shift register, MSB first.
// Load wins over shift; msb is the bit that would go out next.
module piso_shift #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] din,
    output logic         msb
);
    logic [N-1:0] sr;

    // Load a new word or shift the held word left by one.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[N-2:0], 1'b0};
        end
    end

    assign msb = sr[N-1];
endmodule

// File: rtl/reg_readback_tx.sv
// Serial readback of one register word: N data bits MSB-first
// followed by an even-parity bit, one request at a time.
module reg_readback_tx
    import readback_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4,
    parameter int A = 2
) (
    input  logic          clk,
    input  logic          clr,
    reg_readback_tx_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          par, par_d;

    logic busy_q, sdo_q, sframe_q, done_q, err_q;
    logic busy_d, sdo_d, sframe_d, done_d, err_d;

    logic         load, shift, sr_msb;
    logic [N-1:0] w_sel;
    logic         in_range;

    // Pick the addressed word; anything at or beyond M is invalid.
    always_comb begin
        w_sel    = '0;
        in_range = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (bus.rd_addr == A'(i)) begin
                w_sel    = bus.regs_flat[i*N +: N];
                in_range = 1'b1;
            end
        end
    end

    // The MSB goes straight to sdo on capture, so the shifter is
    // loaded already advanced by one bit.
    piso_shift #(.N(N)) u_piso (
        .clk   (clk),
        .clr   (clr),
        .load  (load),
        .shift (shift),
        .din   ({w_sel[N-2:0], 1'b0}),
        .msb   (sr_msb)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        par_d    = par;
        busy_d   = 1'b0;
        sdo_d    = 1'b0;
        sframe_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.rd_req) begin
                    if (in_range) begin
                        load     = 1'b1;
                        par_d    = even_parity(64'(w_sel));
                        sdo_d    = w_sel[N-1];
                        sframe_d = 1'b1;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        state_d  = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                busy_d   = 1'b1;
                sframe_d = 1'b1;
                if (cnt == LAST) begin
                    sdo_d   = par;
                    state_d = PARITY;
                end else begin
                    sdo_d = sr_msb;
                    shift = 1'b1;
                    cnt_d = cnt + 1'b1;
                end
            end
            PARITY: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, parity and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            cnt      <= '0;
            par      <= 1'b0;
            busy_q   <= 1'b0;
            sdo_q    <= 1'b0;
            sframe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            par      <= par_d;
            busy_q   <= busy_d;
            sdo_q    <= sdo_d;
            sframe_q <= sframe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.sdo    = sdo_q;
    assign bus.sframe = sframe_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_reg_readback_tx.sv
// Directed + randomized bench for reg_readback_tx with an
// arithmetic frame model; main DUT M=4, second DUT M=3.
module tb_reg_readback_tx;
    localparam int N = 8;
    localparam int A = 2;

    logic clk = 1'b0;
    logic clr;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] mem [4];

    always #5 clk = ~clk;

    reg_readback_tx_if #(.N(N), .M(4), .A(A)) bus  ();
    reg_readback_tx_if #(.N(N), .M(3), .A(A)) bus3 ();

    reg_readback_tx #(.N(N), .M(4), .A(A)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    reg_readback_tx #(.N(N), .M(3), .A(A)) dut3 (
        .clk (clk),
        .clr (clr),
        .bus (bus3)
    );

    always_comb bus.regs_flat  = {mem[3], mem[2], mem[1], mem[0]};
    always_comb bus3.regs_flat = {mem[2], mem[1], mem[0]};

    // {busy, sframe, sdo, done, err}
    function automatic logic [4:0] outs();
        return {bus.busy, bus.sframe, bus.sdo, bus.done, bus.err};
    endfunction

    function automatic logic [4:0] outs3();
        return {bus3.busy, bus3.sframe, bus3.sdo, bus3.done, bus3.err};
    endfunction

    // Frame bit i: data MSB-first for i<N, then even parity.
    function automatic logic exp_bit(input logic [7:0] w, input int i);
        if (i < N) return 1'((w >> (N - 1 - i)) & 8'd1);
        return 1'($countones(w) % 2);
    endfunction

    task automatic chk(input string tag, input logic [4:0] obs,
                       input logic [4:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, want);
        end
    endtask

    task automatic request(input logic [1:0] addr);
        @(negedge clk);
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        @(negedge clk);
        bus.rd_req = 1'b0;
    endtask

    // Checks ncyc frame cycles starting at the current negedge.
    // At cycle dis a stray request is raised and word0 is cleared.
    task automatic check_bits(input logic [7:0] w, input int ncyc,
                              input int dis);
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge clk);
            if (i == dis) begin
                bus.rd_req  = 1'b1;
                bus.rd_addr = 2'd1;
                mem[0]      = 8'h00;
            end else if (i == dis + 1) begin
                bus.rd_req = 1'b0;
            end
            chk($sformatf("frame_bit%0d", i), outs(),
                {1'b1, 1'b1, exp_bit(w, i), 1'b0, 1'b0});
        end
    endtask

    task automatic check_done();
        @(negedge clk);
        chk("done_pulse", outs(), 5'b00010);
        @(negedge clk);
        chk("after_done", outs(), 5'b00000);
    endtask

    initial begin
        logic [7:0] w;
        logic [1:0] a;

        clr          = 1'b1;
        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
        bus3.rd_req  = 1'b0;
        bus3.rd_addr = '0;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;

        #12;
        chk("reset_main", outs(), 5'b00000);
        chk("reset_m3", outs3(), 5'b00000);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("idle_noreq", outs(), 5'b00000);

        mem[2] = 8'hA5;
        request(2'd2);
        check_bits(8'hA5, N + 1, -1);
        check_done();

        mem[1] = 8'h07;
        request(2'd1);
        check_bits(8'h07, N + 1, -1);
        check_done();

        @(negedge clk);
        bus3.rd_req  = 1'b1;
        bus3.rd_addr = 2'd3;
        @(negedge clk);
        bus3.rd_req = 1'b0;
        chk("oor_err", outs3(), 5'b00001);
        @(negedge clk);
        chk("oor_clear", outs3(), 5'b00000);
        @(negedge clk);
        chk("oor_nodone", outs3(), 5'b00000);

        mem[0] = 8'hFF;
        mem[1] = 8'h5A;
        request(2'd0);
        check_bits(8'hFF, N + 1, 2);
        check_done();
        @(negedge clk);
        chk("no_second", outs(), 5'b00000);

        mem[3] = 8'h3C;
        request(2'd3);
        check_bits(8'h3C, 4, -1);
        #2 clr = 1'b1;
        #1 chk("abort_async", outs(), 5'b00000);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("abort_nodone", outs(), 5'b00000);
        request(2'd3);
        check_bits(8'h3C, N + 1, -1);
        check_done();

        mem[1] = 8'hC3;
        mem[2] = 8'h81;
        request(2'd1);
        check_bits(8'hC3, N + 1, -1);
        @(negedge clk);
        chk("b2b_done", outs(), 5'b00010);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 2'd2;
        @(negedge clk);
        chk("b2b_gap", outs(), 5'b00000);
        @(negedge clk);
        bus.rd_req = 1'b0;
        check_bits(8'h81, N + 1, -1);
        check_done();

        for (int k = 0; k < 6; k++) begin
            a      = 2'($urandom_range(0, 3));
            w      = 8'($urandom);
            mem[a] = w;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            request(a);
            check_bits(w, N + 1, -1);
            check_done();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
